// File: rtl/vga_sync_receiver.sv
`timescale 1ns/1ps
// VGA sync receiver: measures Hsync/Vsync timing, locks onto a stable
// H_TOTAL x V_TOTAL raster and emits active-pixel coordinates with colour.
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int H_START     = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 521,
  parameter int V_START     = 29,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iHsync,
  input  logic       iVsync,
  input  logic [2:0] iRGB,
  output logic [2:0] oRGB,
  output logic [9:0] oPixelX,
  output logic [9:0] oPixelY,
  output logic       oPixelValid,
  output logic [9:0] oLineLength,
  output logic [9:0] oFrameLines,
  output logic       oLocked,
  output logic       oFrameStart,
  output logic       oError,
  output logic [7:0] oErrCount
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Timing constants widened so "+1" comparisons never wrap.
  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] V_LIMIT_C = 11'(V_TOTAL + 1);
  localparam logic [9:0]  H_START_C = 10'(H_START);
  localparam logic [10:0] H_END_C   = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_START_C = 10'(V_START);
  localparam logic [10:0] V_END_C   = 11'(V_START + V_ACTIVE);
  localparam logic [2:0]  LOCK_C    = 3'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX_C = 10'd1023;

  logic       hsync_r, vsync_r;
  logic [2:0] rgb_r;
  logic [9:0] hcount_r, vcount_r;
  state_t     state_r, state_nxt_s;
  logic [2:0] goodcnt_r, goodcnt_nxt_s;
  logic       bad_r, bad_nxt_s;
  logic       err_s, fs_pulse_s;

  // Sync edges: a rising edge is the current input high while the sample is low.
  logic        line_start_s, frame_start_s, line_bad_s, hsat_s;
  logic [10:0] hcount_inc_s, vcount_inc_s;
  logic        h_active_s, v_active_s, pix_valid_s;

  assign line_start_s  = iHsync & ~hsync_r;
  assign frame_start_s = iVsync & ~vsync_r;
  assign hcount_inc_s  = {1'b0, hcount_r} + 11'd1;
  assign vcount_inc_s  = {1'b0, vcount_r} + 11'd1;
  assign line_bad_s    = line_start_s && (hcount_inc_s != H_TOTAL_C);
  assign hsat_s        = (hcount_r == CNT_MAX_C);
  assign h_active_s    = (hcount_r >= H_START_C) && ({1'b0, hcount_r} < H_END_C);
  assign v_active_s    = (vcount_r >= V_START_C) && ({1'b0, vcount_r} < V_END_C);
  assign pix_valid_s   = (state_r == LOCKED) && h_active_s && v_active_s;

  // Sample registers for sync edge detection and colour pipelining; syncs idle high.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
      rgb_r   <= 3'b111;
    end else begin
      hsync_r <= iHsync;
      vsync_r <= iVsync;
      rgb_r   <= iRGB;
    end
  end

  // Horizontal/vertical position counters and measured line/frame lengths.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hcount_r    <= 10'd0;
      vcount_r    <= 10'd0;
      oLineLength <= 10'd0;
      oFrameLines <= 10'd0;
    end else begin
      if (line_start_s) begin
        hcount_r    <= 10'd0;
        oLineLength <= hcount_inc_s[9:0];
      end else if (!hsat_s) begin
        hcount_r <= hcount_r + 10'd1;
      end
      if (frame_start_s) begin
        vcount_r    <= 10'd0;
        oFrameLines <= vcount_inc_s[9:0];
      end else if (line_start_s && (vcount_r != CNT_MAX_C)) begin
        vcount_r <= vcount_r + 10'd1;
      end
    end
  end

  // Lock FSM next-state logic: qualify frames in ACQUIRE, watch for loss in LOCKED.
  always_comb begin
    state_nxt_s   = state_r;
    goodcnt_nxt_s = goodcnt_r;
    bad_nxt_s     = bad_r;
    err_s         = 1'b0;
    fs_pulse_s    = 1'b0;
    case (state_r)
      SEARCH: begin
        if (frame_start_s) begin
          state_nxt_s   = ACQUIRE;
          goodcnt_nxt_s = 3'd0;
          bad_nxt_s     = 1'b0;
        end else begin
          state_nxt_s = SEARCH;
        end
      end
      ACQUIRE: begin
        if (hsat_s) begin
          state_nxt_s = SEARCH;
        end else if (frame_start_s) begin
          bad_nxt_s = 1'b0;
          if (!bad_r && !line_bad_s && (vcount_inc_s == V_TOTAL_C)) begin
            goodcnt_nxt_s = goodcnt_r + 3'd1;
            if ((goodcnt_r + 3'd1) >= LOCK_C) begin
              state_nxt_s = LOCKED;
            end else begin
              state_nxt_s = ACQUIRE;
            end
          end else begin
            goodcnt_nxt_s = 3'd0;
          end
        end else if (line_bad_s) begin
          bad_nxt_s = 1'b1;
        end else begin
          bad_nxt_s = bad_r;
        end
      end
      LOCKED: begin
        if (hsat_s || line_bad_s ||
            (frame_start_s && (vcount_inc_s != V_TOTAL_C)) ||
            (!frame_start_s && ({1'b0, vcount_r} == V_LIMIT_C))) begin
          state_nxt_s = SEARCH;
          err_s       = 1'b1;
        end else if (frame_start_s) begin
          fs_pulse_s = 1'b1;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: begin
        state_nxt_s   = SEARCH;
        goodcnt_nxt_s = 3'd0;
        bad_nxt_s     = 1'b0;
      end
    endcase
  end

  // Lock FSM state and status outputs (lock flag, frame pulse, loss-of-lock events).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= SEARCH;
      goodcnt_r   <= 3'd0;
      bad_r       <= 1'b0;
      oLocked     <= 1'b0;
      oFrameStart <= 1'b0;
      oError      <= 1'b0;
      oErrCount   <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      goodcnt_r   <= goodcnt_nxt_s;
      bad_r       <= bad_nxt_s;
      oLocked     <= (state_nxt_s == LOCKED);
      oFrameStart <= fs_pulse_s;
      oError      <= err_s;
      if (err_s && (oErrCount != 8'hFF)) begin
        oErrCount <= oErrCount + 8'd1;
      end
    end
  end

  // Pixel output stage: colour and coordinates one clock after the counters.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oPixelValid <= 1'b0;
      oPixelX     <= 10'd0;
      oPixelY     <= 10'd0;
      oRGB        <= 3'b000;
    end else begin
      oPixelValid <= pix_valid_s;
      oPixelX     <= pix_valid_s ? (hcount_r - H_START_C) : 10'd0;
      oPixelY     <= pix_valid_s ? (vcount_r - V_START_C) : 10'd0;
      oRGB        <= pix_valid_s ? rgb_r : 3'b000;
    end
  end

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameter H_TOTAL, default 800: expected clocks per line.
REQ-002 Parameter H_START, default 48: clocks from line start to the first active pixel.
REQ-003 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-004 Parameter V_TOTAL, default 521: expected lines per frame.
REQ-005 Parameters V_START, default 29, and V_ACTIVE, default 480: first active line and active line count.
REQ-006 Parameter LOCK_FRAMES, default 2: consecutive good frames required to reach lock.
REQ-007 Clock  in  1  pixel clock; Reset  in  1  reset, synchronous, active-high.
REQ-008 iHsync  in  1  horizontal sync, active-low pulse; iVsync  in  1  vertical sync, active-low pulse.
REQ-009 iRGB  in  3  pixel colour {R,G,B}.
REQ-010 oRGB  out  3  registered pixel colour, aligned with oPixelX/oPixelY.
REQ-011 oPixelX  out  10  active column; oPixelY  out  10  active row; oPixelValid  out  1  active pixel qualifier.
REQ-012 oLineLength  out  10  last measured line length; oFrameLines  out  10  last measured line count.
REQ-013 oLocked  out  1  timing locked; oFrameStart  out  1  one-cycle frame pulse; oError  out  1  one-cycle loss-of-lock pulse; oErrCount  out  8  loss-of-lock events.

Function
REQ-014 The block SHALL register iHsync, iVsync and iRGB every clock into sample registers; line start = iHsync 1 with sampled iHsync 0; frame start = same rule on iVsync.
REQ-015 hcount (10 bit) SHALL load 0 on a line start, else increment, saturating at 1023.
REQ-016 On a line start, oLineLength SHALL load hcount+1.
REQ-017 vcount (10 bit) SHALL load 0 on a frame start, increment on a line start otherwise, and saturate at 1023; a simultaneous frame start takes priority.
REQ-018 On a frame start, oFrameLines SHALL load vcount+1.
REQ-019 The FSM SHALL have states SEARCH, ACQUIRE and LOCKED, with a 3-bit goodcnt and a per-frame sticky flag bad.
REQ-020 SEARCH SHALL move to ACQUIRE on a frame start, clearing goodcnt and bad; no checks are made in SEARCH.
REQ-021 In ACQUIRE or LOCKED, a line start with hcount+1 != H_TOTAL SHALL set bad.
REQ-022 In ACQUIRE, a frame start SHALL evaluate the frame as good only if bad=0 (including the same-edge line check) and vcount+1 == V_TOTAL.
REQ-023 In ACQUIRE, a good frame SHALL increment goodcnt and move to LOCKED when the count reaches LOCK_FRAMES; a bad frame SHALL zero goodcnt and stay in ACQUIRE; bad clears at each frame start.
REQ-024 LOCKED SHALL move to SEARCH on any line-length mismatch, on a frame start with vcount+1 != V_TOTAL, or when vcount reaches V_TOTAL+1 with no frame start.
REQ-025 ACQUIRE or LOCKED SHALL move to SEARCH when hcount saturates at 1023 (lost Hsync).
REQ-026 Every LOCKED->SEARCH transition SHALL pulse oError for one cycle and increment oErrCount, saturating at 255; ACQUIRE->SEARCH SHALL NOT pulse oError.
REQ-027 oLocked SHALL be registered high exactly while state is LOCKED.
REQ-028 oFrameStart SHALL pulse one cycle after a frame start accepted in LOCKED, with no transition out.
REQ-029 Output stage, registered one clock after counters: oPixelValid = LOCKED && H_START<=hcount<H_START+H_ACTIVE && V_START<=vcount<V_START+V_ACTIVE.
REQ-030 oPixelX = hcount-H_START and oPixelY = vcount-V_START when valid, else 0; oRGB = sampled iRGB when valid, else 3'b000.
REQ-031 Input-to-output latency SHALL be exactly 2 clocks: iRGB sampled at edge k appears on oRGB after edge k+1, tagged with its own coordinates.
REQ-032 Lock acquisition SHALL occur no earlier than the (LOCK_FRAMES+1)th frame start after leaving SEARCH.

Reset
REQ-033 With Reset high at a rising Clock edge, the block SHALL enter SEARCH and clear all counters, goodcnt, bad and sample registers.
REQ-034 Sample registers SHALL clear to 1 (sync idle high); outputs oRGB, oPixelX/Y, oPixelValid, oLineLength, oFrameLines, oLocked, oFrameStart, oError and oErrCount SHALL clear to 0.
REQ-035 Reset asserted mid-frame or while LOCKED SHALL NOT pulse oError.

Verification
REQ-036 Nominal 800x521 timing (Hsync low 96, Vsync low 1 line) from reset -> oLocked rises on the 3rd frame start; oLineLength=800, oFrameLines=521.
REQ-037 Locked; drive iRGB=3'b010 at active pixel (0,0) -> oRGB=010, oPixelX=0, oPixelY=0, oPixelValid=1 two clocks after that sample; oPixelValid=0 at hcount=47 and 688.
REQ-038 Locked; one line shortened to 799 clocks -> oError one-cycle pulse, oErrCount=1, oLocked=0, state SEARCH; relock 3 frames later.
REQ-039 Hsync held high for 1100 clocks while LOCKED -> hcount saturates at 1023, oError pulses, oLocked=0.
REQ-040 Frame of 520 lines during ACQUIRE -> goodcnt returns to 0, no oError; lock is achieved only after 2 further good frames.
REQ-041 Reset pulsed mid-frame while LOCKED -> all outputs 0 next cycle, oErrCount=0, no oError pulse.
